// File: rtl/zircon_avalon_key.sv
// Avalon-MM key input: sync -> tick debounce -> press capture -> maskable level irq.
// Read latency 1; pin-to-debounced within 2+2P cycles, irq one cycle later; no backpressure.
module zircon_avalon_key #(
    parameter int KEY_WIDTH        = 4,
    parameter int DEBOUNCE_DEFAULT = 1000000
) (
    input  logic                 csi_clk,
    input  logic                 rsi_reset_n,
    input  logic [1:0]           avs_address,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic                 ins_irq,
    input  logic [KEY_WIDTH-1:0] coe_key
);

    localparam logic [19:0] PERIOD_RST = 20'(DEBOUNCE_DEFAULT);
    localparam logic [1:0]  ADDR_DATA   = 2'd0;
    localparam logic [1:0]  ADDR_EDGE   = 2'd1;
    localparam logic [1:0]  ADDR_MASK   = 2'd2;
    localparam logic [1:0]  ADDR_PERIOD = 2'd3;

    logic [KEY_WIDTH-1:0] sync1_q, sync2_q;
    logic [KEY_WIDTH-1:0] s_prev_q, s_prev_d;
    logic [KEY_WIDTH-1:0] deb_q, deb_d;
    logic [KEY_WIDTH-1:0] edge_q, edge_d;
    logic [KEY_WIDTH-1:0] mask_q, mask_d;
    logic [19:0]          period_q, period_d;
    logic [19:0]          presc_q, presc_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;

    logic                 wr_edge, wr_mask, wr_period;
    logic [19:0]          period_eff;
    logic                 tick;
    logic [KEY_WIDTH-1:0] stable;
    logic [KEY_WIDTH-1:0] press;
    logic [KEY_WIDTH-1:0] w1c;
    logic [31:0]          rd_val;
    logic                 unused_wdata;

    assign wr_edge   = avs_write && (avs_address == ADDR_EDGE);
    assign wr_mask   = avs_write && (avs_address == ADDR_MASK);
    assign wr_period = avs_write && (avs_address == ADDR_PERIOD);

    // Writes to DATA and the bus bits above each register's width are dropped.
    assign unused_wdata = ^avs_writedata;

    // A stored period of 0 runs the prescaler as if it were 1.
    assign period_eff = (period_q == 20'd0) ? 20'd1 : period_q;
    assign tick       = (presc_q == (period_eff - 20'd1));

    always_comb begin
        presc_d = presc_q + 20'd1;
        if (wr_period || tick) begin
            presc_d = 20'd0;
        end
    end

    // A bit only follows sync2 when it matched the value latched on the previous tick.
    assign stable = ~(sync2_q ^ s_prev_q);

    always_comb begin
        s_prev_d = s_prev_q;
        deb_d    = deb_q;
        if (tick) begin
            s_prev_d = sync2_q;
            deb_d    = (stable & sync2_q) | (~stable & deb_q);
        end
    end

    assign press = deb_q & ~deb_d;
    assign w1c   = wr_edge ? avs_writedata[KEY_WIDTH-1:0] : '0;

    // A press landing on the same edge as a W1C keeps the bit set.
    assign edge_d = (edge_q & ~w1c) | press;
    assign mask_d = wr_mask ? avs_writedata[KEY_WIDTH-1:0] : mask_q;
    assign period_d = wr_period ? avs_writedata[19:0] : period_q;
    assign irq_d  = |(edge_q & mask_q);

    always_comb begin
        rd_val = '0;
        case (avs_address)
            ADDR_DATA:   rd_val[KEY_WIDTH-1:0] = ~deb_q;
            ADDR_EDGE:   rd_val[KEY_WIDTH-1:0] = edge_q;
            ADDR_MASK:   rd_val[KEY_WIDTH-1:0] = mask_q;
            ADDR_PERIOD: rd_val[19:0]          = period_q;
            default:     rd_val                = '0;
        endcase
    end

    assign rdata_d = avs_read ? rd_val : rdata_q;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            s_prev_q <= '1;
            deb_q    <= '1;
            edge_q   <= '0;
            mask_q   <= '0;
            period_q <= PERIOD_RST;
            presc_q  <= 20'd0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= coe_key;
            sync2_q  <= sync1_q;
            s_prev_q <= s_prev_d;
            deb_q    <= deb_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign ins_irq      = irq_q;

endmodule

// File: tb/tb_zircon_avalon_key.sv
// Scoreboarded bench for zircon_avalon_key: directed scenarios followed by random bus/pin traffic.
module tb_zircon_avalon_key;

    localparam int KW  = 4;
    localparam int DEF = 1000000;

    logic          csi_clk = 1'b0;
    logic          rsi_reset_n;
    logic [1:0]    avs_address;
    logic          avs_read;
    logic [31:0]   avs_readdata;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic          ins_irq;
    logic [KW-1:0] coe_key;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rd_q[$];
    logic        irq_q[$];

    // Reference model state: pin samples from the last two edges, the value seen
    // at the previous tick, and the architectural registers.
    logic [KW-1:0] m_hist1, m_hist2, m_last_tick, m_deb, m_edge, m_mask;
    logic [19:0]   m_period;
    int            m_cnt;
    logic          m_irq;

    zircon_avalon_key #(.KEY_WIDTH(KW), .DEBOUNCE_DEFAULT(DEF)) dut (
        .csi_clk       (csi_clk),
        .rsi_reset_n   (rsi_reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .ins_irq       (ins_irq),
        .coe_key       (coe_key)
    );

    always #5 csi_clk = ~csi_clk;

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, ~m_deb};
            2'd1:    return {28'd0, m_edge};
            2'd2:    return {28'd0, m_mask};
            default: return {12'd0, m_period};
        endcase
    endfunction

    task automatic m_reset();
        m_hist1     = '1;
        m_hist2     = '1;
        m_last_tick = '1;
        m_deb       = '1;
        m_edge      = '0;
        m_mask      = '0;
        m_period    = 20'(DEF);
        m_cnt       = 0;
        m_irq       = 1'b0;
    endtask

    task automatic m_step();
        int            p;
        logic [KW-1:0] seen, nd, press;
        p = (m_period == 20'd0) ? 1 : int'(m_period);
        if (avs_read) rd_q.push_back(m_reg(avs_address));
        seen = m_hist2;
        nd   = m_deb;
        if (m_cnt == p - 1) begin
            for (int i = 0; i < KW; i++) begin
                if (seen[i] == m_last_tick[i]) nd[i] = seen[i];
            end
            m_last_tick = seen;
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (avs_write && avs_address == 2'd3) m_cnt = 0;
        press = m_deb & ~nd;
        m_irq = |(m_edge & m_mask);
        if (avs_write && avs_address == 2'd1) m_edge = m_edge & ~avs_writedata[KW-1:0];
        m_edge = m_edge | press;
        if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[KW-1:0];
        if (avs_write && avs_address == 2'd3) m_period = avs_writedata[19:0];
        m_deb   = nd;
        m_hist2 = m_hist1;
        m_hist1 = coe_key;
        irq_q.push_back(m_irq);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge csi_clk or negedge rsi_reset_n);
            if (!rsi_reset_n) m_reset();
            else m_step();
        end
    end

    // Monitor: pops expected irq every live cycle and expected readdata after each read.
    logic        mon_rd, mon_live;
    logic [31:0] mon_exp;
    logic        mon_irq;
    initial begin
        forever begin
            @(posedge csi_clk);
            mon_rd   = avs_read;
            mon_live = rsi_reset_n;
            #1;
            if (mon_live) begin
                n_tests++;
                if (irq_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_irq: no expected value queued, got %0b", ins_irq);
                end else begin
                    mon_irq = irq_q.pop_front();
                    if (ins_irq !== mon_irq) begin
                        n_fail++;
                        $display("FAIL sb_irq @%0t: got %0b, expected %0b", $time, ins_irq, mon_irq);
                    end
                end
                if (mon_rd) begin
                    n_tests++;
                    if (rd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_read: no expected value queued, got 0x%08h", avs_readdata);
                    end else begin
                        mon_exp = rd_q.pop_front();
                        if (avs_readdata !== mon_exp) begin
                            n_fail++;
                            $display("FAIL sb_read @%0t: got 0x%08h, expected 0x%08h", $time, avs_readdata, mon_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge csi_clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge csi_clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge csi_clk);
        avs_read    = 1'b0;
        d = avs_readdata;
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        rsi_reset_n   = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        coe_key       = '1;
        cyc(3);
        rsi_reset_n = 1'b1;
        cyc(1);

        chk("rst_irq", {31'd0, ins_irq}, 32'd0);
        rd(2'd0, d); chk("rst_data", d, 32'd0);
        rd(2'd1, d); chk("rst_edge", d, 32'd0);
        rd(2'd2, d); chk("rst_mask", d, 32'd0);
        rd(2'd3, d); chk("rst_period", d, 32'(DEF));

        // Exact latency with P=1, then W1C drops irq.
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd1);
        cyc(3);
        coe_key[0] = 1'b0;
        cyc(3);
        rd(2'd0, d); chk("data_before_k3", d, 32'd0);
        chk("irq_at_k3", {31'd0, ins_irq}, 32'd0);
        rd(2'd0, d); chk("data_at_k3", d, 32'd1);
        chk("irq_at_k4", {31'd0, ins_irq}, 32'd1);
        rd(2'd1, d); chk("edge_at_k3", d, 32'd1);
        wr(2'd1, 32'd1);
        chk("irq_after_w1c_1", {31'd0, ins_irq}, 32'd1);
        cyc(1);
        chk("irq_after_w1c_2", {31'd0, ins_irq}, 32'd0);
        coe_key = '1;
        cyc(6);

        // Glitch shorter than a tick is filtered; a held press arrives within bound.
        wr(2'd3, 32'd10);
        coe_key[2] = 1'b0;
        cyc(5);
        coe_key[2] = 1'b1;
        cyc(40);
        rd(2'd0, d); chk("glitch_data", d, 32'd0);
        rd(2'd1, d); chk("glitch_edge", d, 32'd0);
        coe_key[2] = 1'b0;
        n = 0;
        d = 32'd0;
        while (!d[2] && n < 40) begin
            rd(2'd0, d);
            n++;
        end
        n_tests++;
        if (!(d[2] && n <= 23)) begin
            n_fail++;
            $display("FAIL deb_latency: took %0d reads, required at most 23", n);
        end
        coe_key = '1;
        cyc(30);
        wr(2'd1, 32'hF);

        // Masked capture, then unmasking raises irq one cycle after the write.
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd0);
        coe_key[1] = 1'b0;
        cyc(6);
        rd(2'd1, d); chk("masked_edge", d, 32'd2);
        chk("masked_irq", {31'd0, ins_irq}, 32'd0);
        wr(2'd2, 32'd2);
        chk("unmask_irq_0", {31'd0, ins_irq}, 32'd0);
        cyc(1);
        chk("unmask_irq_1", {31'd0, ins_irq}, 32'd1);
        coe_key = '1;
        cyc(6);
        wr(2'd1, 32'd2);
        cyc(2);
        chk("unmask_irq_cleared", {31'd0, ins_irq}, 32'd0);

        // Press lands on the same edge as a W1C of that bit.
        wr(2'd2, 32'd0);
        coe_key[0] = 1'b0;
        cyc(3);
        wr(2'd1, 32'd1);
        rd(2'd1, d); chk("set_beats_clear", d, 32'd1);
        coe_key = '1;
        cyc(6);
        wr(2'd1, 32'hF);

        // Asynchronous reset while a key is held, then recapture.
        wr(2'd2, 32'd8);
        wr(2'd3, 32'd1);
        coe_key[3] = 1'b0;
        cyc(6);
        rd(2'd2, d); chk("pre_rst_mask", d, 32'd8);
        chk("pre_rst_irq", {31'd0, ins_irq}, 32'd1);
        #3;
        rsi_reset_n = 1'b0;
        #1;
        chk("async_rst_irq", {31'd0, ins_irq}, 32'd0);
        chk("async_rst_rdata", avs_readdata, 32'd0);
        cyc(2);
        rsi_reset_n = 1'b1;
        rd(2'd1, d); chk("post_rst_edge", d, 32'd0);
        rd(2'd3, d); chk("post_rst_period", d, 32'(DEF));
        wr(2'd3, 32'd1);
        wr(2'd2, 32'd8);
        cyc(8);
        rd(2'd1, d); chk("recapture_edge", d, 32'd8);
        chk("recapture_irq", {31'd0, ins_irq}, 32'd1);
        coe_key = '1;
        cyc(6);
        wr(2'd1, 32'hF);
        cyc(2);

        // Random traffic, including simultaneous read/write, against the model.
        for (int i = 0; i < 1500; i++) begin
            avs_read      = ($urandom_range(0, 2) == 0);
            avs_write     = ($urandom_range(0, 4) == 0);
            avs_address   = 2'($urandom_range(0, 3));
            avs_writedata = $urandom;
            if (avs_address == 2'd3) avs_writedata = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) coe_key = KW'($urandom);
            @(negedge csi_clk);
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
